// File: rtl/mogol_yaris_kontrol.sv
// mogol_yaris_kontrol: horse race betting controller.
// A bet taken in BOSTA starts a race of three horses with latched speeds.
// The first horse past position 512 wins. Beyaz has priority over siyah,
// and siyah over boz, on a simultaneous finish. After 255 race steps with
// no finisher the race times out. The balance is charged the stake when
// the bet is accepted and credited three times the stake on a correct
// guess, saturating at the 14-bit signed limits.
module mogol_yaris_kontrol (
    input  logic        saat,
    input  logic        reset,
    input  logic        bahis_gecerli,
    output logic        bahis_hazir,
    input  logic [1:0]  tahmin_edilen_at,
    input  logic [6:0]  yatirilan_para,
    input  logic [3:0]  beyaz_hiz,
    input  logic [3:0]  siyah_hiz,
    input  logic [3:0]  boz_hiz,
    output logic [1:0]  durum,
    output logic [1:0]  kazanan_at,
    output logic        yaris_bitti,
    output logic [13:0] bakiye
);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        KOSU  = 2'd1,
        SONUC = 2'd2
    } durum_t;

    localparam logic [9:0]  BITIS_CIZGISI = 10'd512;
    localparam logic [7:0]  SON_ADIM      = 8'd254;
    localparam logic [1:0]  AT_YOK        = 2'd0;
    localparam logic [1:0]  AT_BEYAZ      = 2'd1;
    localparam logic [1:0]  AT_SIYAH      = 2'd2;
    localparam logic [1:0]  AT_BOZ        = 2'd3;

    durum_t      durum_q;
    durum_t      durum_d;

    logic [1:0]  tahmin_q;
    logic [6:0]  stake_q;
    logic [3:0]  beyaz_hiz_q;
    logic [3:0]  siyah_hiz_q;
    logic [3:0]  boz_hiz_q;

    logic [9:0]  beyaz_konum_q;
    logic [9:0]  siyah_konum_q;
    logic [9:0]  boz_konum_q;
    logic [7:0]  adim_q;

    logic [1:0]  kazanan_q;
    logic [13:0] bakiye_q;
    logic [13:0] bakiye_d;

    logic        bahis_kabul;
    logic [9:0]  beyaz_konum_yeni;
    logic [9:0]  siyah_konum_yeni;
    logic [9:0]  boz_konum_yeni;
    logic        beyaz_bitti;
    logic        siyah_bitti;
    logic        boz_bitti;
    logic        biri_bitti;
    logic        sure_doldu;
    logic        yaris_sonu;
    logic [1:0]  kazanan_d;

    logic signed [15:0] bakiye_genis;
    logic signed [15:0] stake_giris_genis;
    logic signed [15:0] odeme_genis;

    // Advance a position by a speed, clamping at the top of the 10-bit range
    function automatic logic [9:0] ilerle(input logic [9:0] konum, input logic [3:0] hiz);
        logic [10:0] toplam;
        toplam = {1'b0, konum} + {7'b0, hiz};
        if (toplam[10]) begin
            return 10'h3FF;
        end
        return toplam[9:0];
    endfunction

    // Clamp a wide signed balance into the 14-bit signed range
    function automatic logic [13:0] doyur(input logic signed [15:0] deger);
        if (deger > 16'sd8191) begin
            return 14'h1FFF;
        end
        if (deger < -16'sd8192) begin
            return 14'h2000;
        end
        return deger[13:0];
    endfunction

    // Bet acceptance and race progress decode
    always_comb begin
        bahis_kabul      = 1'b0;
        beyaz_konum_yeni = ilerle(beyaz_konum_q, beyaz_hiz_q);
        siyah_konum_yeni = ilerle(siyah_konum_q, siyah_hiz_q);
        boz_konum_yeni   = ilerle(boz_konum_q, boz_hiz_q);
        beyaz_bitti      = beyaz_konum_yeni >= BITIS_CIZGISI;
        siyah_bitti      = siyah_konum_yeni >= BITIS_CIZGISI;
        boz_bitti        = boz_konum_yeni >= BITIS_CIZGISI;
        biri_bitti       = beyaz_bitti | siyah_bitti | boz_bitti;
        sure_doldu       = adim_q == SON_ADIM;
        yaris_sonu       = 1'b0;
        kazanan_d        = AT_YOK;

        if (durum_q == BOSTA && bahis_gecerli && tahmin_edilen_at != AT_YOK) begin
            bahis_kabul = 1'b1;
        end

        if (durum_q == KOSU) begin
            yaris_sonu = biri_bitti | sure_doldu;
        end

        if (beyaz_bitti) begin
            kazanan_d = AT_BEYAZ;
        end else if (siyah_bitti) begin
            kazanan_d = AT_SIYAH;
        end else if (boz_bitti) begin
            kazanan_d = AT_BOZ;
        end
    end

    // FSM state register
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            durum_q <= BOSTA;
        end else begin
            durum_q <= durum_d;
        end
    end

    // FSM next-state: one race per accepted bet, one cycle of result
    always_comb begin
        durum_d = durum_q;
        case (durum_q)
            BOSTA: begin
                if (bahis_kabul) begin
                    durum_d = KOSU;
                end
            end
            KOSU: begin
                if (yaris_sonu) begin
                    durum_d = SONUC;
                end
            end
            SONUC: begin
                durum_d = BOSTA;
            end
            default: begin
                durum_d = BOSTA;
            end
        endcase
    end

    // FSM outputs decoded straight from the current state
    always_comb begin
        durum       = durum_q;
        bahis_hazir = durum_q == BOSTA;
        yaris_bitti = durum_q == SONUC;
    end

    // Capture the bet and horse speeds when a bet is accepted
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            tahmin_q    <= AT_YOK;
            stake_q     <= 7'd0;
            beyaz_hiz_q <= 4'd0;
            siyah_hiz_q <= 4'd0;
            boz_hiz_q   <= 4'd0;
        end else if (bahis_kabul) begin
            tahmin_q    <= tahmin_edilen_at;
            stake_q     <= yatirilan_para;
            beyaz_hiz_q <= beyaz_hiz;
            siyah_hiz_q <= siyah_hiz;
            boz_hiz_q   <= boz_hiz;
        end
    end

    // Horse positions and the race step counter
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            beyaz_konum_q <= 10'd0;
            siyah_konum_q <= 10'd0;
            boz_konum_q   <= 10'd0;
            adim_q        <= 8'd0;
        end else if (bahis_kabul) begin
            beyaz_konum_q <= 10'd0;
            siyah_konum_q <= 10'd0;
            boz_konum_q   <= 10'd0;
            adim_q        <= 8'd0;
        end else if (durum_q == KOSU) begin
            beyaz_konum_q <= beyaz_konum_yeni;
            siyah_konum_q <= siyah_konum_yeni;
            boz_konum_q   <= boz_konum_yeni;
            adim_q        <= adim_q + 8'd1;
        end
    end

    // Balance update: stake charged on acceptance, payout on a correct guess
    always_comb begin
        bakiye_genis      = {{2{bakiye_q[13]}}, bakiye_q};
        stake_giris_genis = {9'b0, yatirilan_para};
        odeme_genis       = {8'b0, stake_q, 1'b0} + {9'b0, stake_q};
        bakiye_d          = bakiye_q;
        if (bahis_kabul) begin
            bakiye_d = doyur(bakiye_genis - stake_giris_genis);
        end else if (yaris_sonu && kazanan_d == tahmin_q) begin
            bakiye_d = doyur(bakiye_genis + odeme_genis);
        end
    end

    // Winner is held from one result until the next; balance register
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            kazanan_q <= AT_YOK;
            bakiye_q  <= 14'd0;
        end else begin
            bakiye_q <= bakiye_d;
            if (yaris_sonu) begin
                kazanan_q <= kazanan_d;
            end
        end
    end

    // Drive the registered result outputs
    always_comb begin
        kazanan_at = kazanan_q;
        bakiye     = bakiye_q;
    end

endmodule

// File: doc/mogol_yaris_kontrol.md
MOGOL_YARIS_KONTROL -- requirements
Module: mogol_yaris_kontrol

Interface
REQ-001 SHALL have port: saat  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: bahis_gecerli  input  1  bet valid (handshake request).
REQ-004 SHALL have port: bahis_hazir  output  1  bet ready; high only in BOSTA.
REQ-005 SHALL have port: tahmin_edilen_at  input  2  predicted horse: 1 beyaz, 2 siyah, 3 boz, 0 invalid.
REQ-006 SHALL have port: yatirilan_para  input  7  unsigned stake, 0..127.
REQ-007 SHALL have ports: beyaz_hiz, siyah_hiz, boz_hiz  input  4 each  unsigned per-cycle horse advance.
REQ-008 SHALL have port: durum  output  2  FSM state: 0 BOSTA, 1 KOSU, 2 SONUC.
REQ-009 SHALL have port: kazanan_at  output  2  winner of last race (0 = none/timeout), held until next SONUC.
REQ-010 SHALL have port: yaris_bitti  output  1  one-cycle pulse, high exactly while durum = SONUC.
REQ-011 SHALL have port: bakiye  output  14  two's-complement signed balance.

Function
REQ-012 SHALL accept a bet on the rising edge where bahis_gecerli & bahis_hazir & tahmin_edilen_at != 0; tahmin_edilen_at = 0 is ignored (no state change).
REQ-013 On acceptance SHALL latch tahmin, stake and the three speeds, clear the three 10-bit positions and the 8-bit timeout counter, subtract the stake from bakiye, and enter KOSU.
REQ-014 Inputs SHALL be ignored outside BOSTA; speed changes during KOSU have no effect.
REQ-015 Each KOSU cycle SHALL add each latched speed to its position (no position wrap; 10-bit plus carry or saturate at 1023) and increment the timeout counter.
REQ-016 A horse finishes when its updated position >= 512; on the first edge any horse finishes SHALL enter SONUC with kazanan_at set to the finisher.
REQ-017 Simultaneous finish SHALL resolve by fixed priority beyaz > siyah > boz.
REQ-018 If no horse has finished after the 255th KOSU update SHALL enter SONUC with kazanan_at = 0; a finish on the 255th update takes precedence over timeout.
REQ-019 On the edge entering SONUC, if kazanan_at equals latched tahmin, SHALL add 3 x stake to bakiye (net gain 2 x stake); otherwise bakiye unchanged (stake lost).
REQ-020 All bakiye arithmetic SHALL saturate to range -8192..+8191.
REQ-021 SONUC SHALL last exactly one cycle, then return to BOSTA; bahis_hazir reasserts in BOSTA.
REQ-022 Latency: acceptance edge E0, winner at update n -> SONUC entered at edge En, BOSTA at En+1.

Reset
REQ-023 On reset assertion SHALL immediately force durum = BOSTA, bakiye = 0, kazanan_at = 0, yaris_bitti = 0, bahis_hazir = 1 (after reset release), positions, latches and timeout counter = 0.
REQ-024 Reset during KOSU or SONUC SHALL abort the race with no payout and no further bakiye change.

Verification
REQ-025 Reset: assert reset mid-cycle -> bakiye 0, durum 0, kazanan_at 0, yaris_bitti 0 without a clock edge.
REQ-026 Win: speeds 15/1/1, bet tahmin 1 stake 100 -> bakiye -100 after E0, SONUC at E35 (15x35 = 525), kazanan_at 1, bakiye 200, yaris_bitti one cycle.
REQ-027 Tie: speeds 8/8/8, bet tahmin 2 stake 10 -> SONUC at E64, kazanan_at 1, bakiye -10.
REQ-028 Timeout: speeds 0/0/0, bet tahmin 3 stake 127 -> SONUC at E255, kazanan_at 0, bakiye -127.
REQ-029 Saturation: 33 consecutive winning races stake 127 -> bakiye +8191 after the 33rd (not +8382); invalid tahmin 0 with valid high -> no race, bakiye unchanged.
REQ-030 Abort: reset at KOSU cycle 10 of a stake-50 race -> bakiye 0, durum 0; new bet accepted on the first edge after release.
